// File: rtl/usb_fx2_data_sender_pkg.sv
// Shared definitions for the FX2 slave-FIFO data sender: FSM encoding,
// endpoint address and packet geometry.
package usb_fx2_data_sender_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_PEND = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0]  EP6_ADDR      = 2'b10;
    localparam int unsigned FX2_PKT_WORDS = 256;
    localparam int unsigned FX2_DATA_W    = 16;

    // The FPGA owns the FD bus while a word is being captured or presented.
    function automatic logic drives_bus(input state_t s);
        return (s == ST_CAP) || (s == ST_WR);
    endfunction

endpackage

// File: rtl/usb_fx2_data_sender_if.sv
// Data-FIFO read port, flush/done handshake and FX2 slave-FIFO write port.
// master = the sender, slave = the FIFO/FX2/test-controller side.
interface usb_fx2_data_sender_if;
    import usb_fx2_data_sender_pkg::*;

    logic                  usb_data_fifo_empty;
    logic                  usb_data_fifo_rd_en;
    logic [FX2_DATA_W-1:0] usb_data_fifo_dout;
    logic                  Flush_Req;
    logic                  Data_Transmit_Done;
    logic                  usb_flagb;
    logic                  usb_slwr_n;
    logic                  usb_pktend_n;
    logic [1:0]            usb_fifoaddr;
    logic [FX2_DATA_W-1:0] usb_fd_out;
    logic                  usb_fd_oe;

    modport master (
        input  usb_data_fifo_empty, usb_data_fifo_dout, Flush_Req, usb_flagb,
        output usb_data_fifo_rd_en, Data_Transmit_Done, usb_slwr_n, usb_pktend_n,
               usb_fifoaddr, usb_fd_out, usb_fd_oe
    );

    modport slave (
        output usb_data_fifo_empty, usb_data_fifo_dout, Flush_Req, usb_flagb,
        input  usb_data_fifo_rd_en, Data_Transmit_Done, usb_slwr_n, usb_pktend_n,
               usb_fifoaddr, usb_fd_out, usb_fd_oe
    );

endinterface

// File: rtl/usb_fx2_data_sender.sv
// Drains the 16-bit data FIFO into the FX2 EP6 slave FIFO one word at a time,
// commits short packets with PKTEND on flush and pulses Done when finished.
module usb_fx2_data_sender
    import usb_fx2_data_sender_pkg::*;
#(
    parameter int unsigned PKT_WORDS = FX2_PKT_WORDS,
    parameter logic [1:0]  EP_ADDR   = EP6_ADDR
) (
    input  logic                  Clk,
    input  logic                  reset,
    usb_fx2_data_sender_if.master bus
);

    localparam int unsigned      CNT_W     = $clog2(PKT_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PKT_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_word_cnt;
    logic                  r_flush_pend;
    logic                  r_rd_en;
    logic                  r_done;
    logic                  r_slwr_n;
    logic                  r_pktend_n;
    logic                  r_fd_oe;
    logic [FX2_DATA_W-1:0] r_fd_out;

    logic                  w_rd_en;
    logic                  w_done;
    logic                  w_slwr_n;
    logic                  w_pktend_n;
    logic                  w_fd_oe;
    logic                  w_capture;
    logic                  w_flush_pend;
    logic [CNT_W-1:0]      w_word_cnt;

    // State register
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; pending data always takes priority over a flush
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!bus.usb_data_fifo_empty) begin
                    w_next_state = ST_RD;
                end else if (r_flush_pend) begin
                    w_next_state = (r_word_cnt != CNT_ZERO) ? ST_PEND : ST_DONE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD:   w_next_state = ST_CAP;
            ST_CAP:  w_next_state = ST_WR;
            ST_WR:   w_next_state = bus.usb_flagb ? ST_IDLE : ST_WR;
            ST_PEND: w_next_state = bus.usb_flagb ? ST_DONE : ST_PEND;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: state-level outputs follow the next state so they are
    // valid for the whole state cycle; flagb-gated strobes land one cycle on.
    always_comb begin
        w_rd_en    = (w_next_state == ST_RD);
        w_done     = (w_next_state == ST_DONE);
        w_fd_oe    = drives_bus(w_next_state);
        w_slwr_n   = 1'b1;
        w_pktend_n = 1'b1;
        w_capture  = 1'b0;
        w_word_cnt = r_word_cnt;
        case (r_state)
            ST_CAP: begin
                w_capture = 1'b1;
            end
            ST_WR: begin
                if (bus.usb_flagb) begin
                    w_slwr_n   = 1'b0;
                    w_fd_oe    = 1'b1;
                    w_word_cnt = (r_word_cnt == LAST_WORD) ? CNT_ZERO : r_word_cnt + CNT_ONE;
                end else begin
                    w_slwr_n   = 1'b1;
                end
            end
            ST_PEND: begin
                if (bus.usb_flagb) begin
                    w_pktend_n = 1'b0;
                    w_word_cnt = CNT_ZERO;
                end else begin
                    w_pktend_n = 1'b1;
                end
            end
            default: begin
                w_capture = 1'b0;
            end
        endcase

        if (bus.Flush_Req) begin
            w_flush_pend = 1'b1;
        end else if (r_state == ST_DONE) begin
            w_flush_pend = 1'b0;
        end else begin
            w_flush_pend = r_flush_pend;
        end
    end

    // Output and datapath registers
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_rd_en      <= 1'b0;
            r_done       <= 1'b0;
            r_slwr_n     <= 1'b1;
            r_pktend_n   <= 1'b1;
            r_fd_oe      <= 1'b0;
            r_fd_out     <= {FX2_DATA_W{1'b0}};
            r_word_cnt   <= CNT_ZERO;
            r_flush_pend <= 1'b0;
        end else begin
            r_rd_en      <= w_rd_en;
            r_done       <= w_done;
            r_slwr_n     <= w_slwr_n;
            r_pktend_n   <= w_pktend_n;
            r_fd_oe      <= w_fd_oe;
            r_word_cnt   <= w_word_cnt;
            r_flush_pend <= w_flush_pend;
            if (w_capture) begin
                r_fd_out <= bus.usb_data_fifo_dout;
            end
        end
    end

    assign bus.usb_data_fifo_rd_en = r_rd_en;
    assign bus.Data_Transmit_Done  = r_done;
    assign bus.usb_slwr_n          = r_slwr_n;
    assign bus.usb_pktend_n        = r_pktend_n;
    assign bus.usb_fd_oe           = r_fd_oe;
    assign bus.usb_fd_out          = r_fd_out;
    assign bus.usb_fifoaddr        = EP_ADDR;

endmodule
